// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with its own bit timer; samples mid-bit.
// Bit period is BAUDRATE+1 clk cycles.
// Optional 8E1 build: define UART_RX_PARITY_EN.
// Ports:
//   clk       system clock
//   rst       synchronous active-high reset
//   rx        async serial input, idle high
//   data      last good byte
//   valid     1-cycle pulse, data updated
//   frame_err 1-cycle pulse, bad stop (or parity)
//   busy      receiver not idle
module uart_rx #(
   parameter int BAUDRATE = 1042
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] data,
   output logic       valid,
   output logic       frame_err,
   output logic       busy
);

   localparam logic [16:0] BAUD_L = 17'(BAUDRATE);
   localparam logic [16:0] HALF   = 17'((BAUDRATE + 1) / 2);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_STOP   = 3'd3;
   localparam logic [2:0] S_BREAK  = 3'd4;
`ifdef UART_RX_PARITY_EN
   localparam logic [2:0] S_PARITY = 3'd5;
`endif

   logic        rx_meta_q;
   logic        rx_s_q;
   logic [2:0]  state_q, state_d;
   logic [16:0] ctr_q, ctr_d;
   logic [7:0]  shift_q, shift_d;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  data_q, data_d;
   logic        valid_q, valid_d;
   logic        ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
   logic        perr_q, perr_d;
`endif
   logic        sample;

   assign sample = (state_q != S_IDLE) && (ctr_q == 17'd0);

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      bit_d   = bit_q;
      data_d  = data_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_d  = perr_q;
`endif
      ctr_d   = (ctr_q != 17'd0) ? ctr_q - 17'd1 : ctr_q;
      if (sample) ctr_d = BAUD_L;

      case (state_q)
         S_IDLE: begin
            if (!rx_s_q) begin
               ctr_d   = HALF;
               state_d = S_START;
            end
         end
         S_START: begin
            if (sample) begin
               if (!rx_s_q) begin
                  state_d = S_DATA;
                  bit_d   = 3'd0;
               end else begin
                  // too short to be a start bit
                  state_d = S_IDLE;
               end
            end
         end
         S_DATA: begin
            if (sample) begin
               shift_d = {rx_s_q, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (sample) begin
               perr_d  = ^{shift_q, rx_s_q};
               state_d = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (sample) begin
               if (rx_s_q) begin
`ifdef UART_RX_PARITY_EN
                  if (perr_q) begin
                     ferr_d = 1'b1;
                  end else begin
                     data_d  = shift_q;
                     valid_d = 1'b1;
                  end
`else
                  data_d  = shift_q;
                  valid_d = 1'b1;
`endif
                  // leave at mid-stop so a back-to-back start is seen
                  state_d = S_IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = S_BREAK;
               end
            end
         end
         S_BREAK: begin
            // a held-low line must not look like a new start
            if (rx_s_q) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
         state_q   <= S_IDLE;
         ctr_q     <= 17'd0;
         shift_q   <= 8'd0;
         bit_q     <= 3'd0;
         data_q    <= 8'd0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         perr_q    <= 1'b0;
`endif
      end else begin
         rx_meta_q <= rx;
         rx_s_q    <= rx_meta_q;
         state_q   <= state_d;
         ctr_q     <= ctr_d;
         shift_q   <= shift_d;
         bit_q     <= bit_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
         perr_q    <= perr_d;
`endif
      end
   end

   assign data      = data_q;
   assign valid     = valid_q;
   assign frame_err = ferr_q;
   assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx at BAUDRATE=15.
// Builds with or without UART_RX_PARITY_EN.
module tb_uart_rx;

   localparam int B    = 15;
   localparam int BIT  = B + 1;
   localparam int HALF = BIT / 2;
`ifdef UART_RX_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif
   // first busy cycle to valid cycle
   localparam int LAT   = HALF + (9 + PB) * BIT + 1;
   localparam int FRAME = (10 + PB) * BIT;
   localparam int PER   = 10;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx  = 1'b1;
   logic [7:0] data;
   logic       valid;
   logic       frame_err;
   logic       busy;

   int ncmp = 0;
   int nfail = 0;

   int  vcnt = 0;
   int  fcnt = 0;
   int  both = 0;
   logic [7:0] rxq[$];
   time vtime[$];
   time busy_rise_t = 0;
   logic busy_prev = 1'b0;
   logic busy_at_valid = 1'b1;
   int  busy_run = 0;
   int  busy_max = 0;

   int v0, f0;

   uart_rx #(.BAUDRATE(B)) dut (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .data      (data),
      .valid     (valid),
      .frame_err (frame_err),
      .busy      (busy)
   );

   always #(PER / 2) clk = ~clk;

   always @(negedge clk) begin
      if (valid) begin
         vcnt++;
         rxq.push_back(data);
         vtime.push_back($time);
         busy_at_valid = busy;
      end
      if (frame_err) fcnt++;
      if (valid && frame_err) both++;
      if (busy && !busy_prev) busy_rise_t = $time;
      busy_prev = busy;
      busy_run = busy ? busy_run + 1 : 0;
      if (busy_run > busy_max) busy_max = busy_run;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic bitw(input logic b);
      rx = b;
      repeat (BIT) @(negedge clk);
   endtask

   task automatic frame(input logic [7:0] b, input logic stop);
      bitw(1'b0);
      for (int i = 0; i < 8; i++) bitw(b[i]);
`ifdef UART_RX_PARITY_EN
      bitw(^b);
`endif
      bitw(stop);
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic frame_par(input logic [7:0] b, input logic par);
      bitw(1'b0);
      for (int i = 0; i < 8; i++) bitw(b[i]);
      bitw(par);
      bitw(1'b1);
   endtask
`endif

   initial begin
      rst = 1'b1;
      rx  = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_data", 32'(data), 32'h0);
      chk("rst_valid", 32'(valid), 32'h0);
      chk("rst_ferr", 32'(frame_err), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      // single frame 0xA5
      v0 = vcnt; f0 = fcnt;
      frame(8'hA5, 1'b1);
      repeat (4) @(negedge clk);
      chk("a5_count", 32'(vcnt - v0), 32'd1);
      chk("a5_data", 32'(data), 32'hA5);
      chk("a5_ferr", 32'(fcnt - f0), 32'd0);
      chk("a5_busy_at_valid", 32'(busy_at_valid), 32'd0);
      chk("a5_latency", 32'((vtime[$] - busy_rise_t) / PER), 32'(LAT));
      chk("a5_idle", 32'(busy), 32'd0);

      // back-to-back 0x00, 0xFF
      v0 = vcnt;
      frame(8'h00, 1'b1);
      frame(8'hFF, 1'b1);
      repeat (4) @(negedge clk);
      chk("b2b_count", 32'(vcnt - v0), 32'd2);
      if (vcnt - v0 == 2) begin
         chk("b2b_first", 32'(rxq[rxq.size() - 2]), 32'h00);
         chk("b2b_second", 32'(rxq[rxq.size() - 1]), 32'hFF);
         chk("b2b_gap",
             32'((vtime[vtime.size() - 1] - vtime[vtime.size() - 2]) / PER),
             32'(FRAME));
      end

      // 4-cycle glitch
      busy_max = 0;
      v0 = vcnt; f0 = fcnt;
      rx = 1'b0;
      repeat (4) @(negedge clk);
      rx = 1'b1;
      repeat (30) @(negedge clk);
      chk("glitch_valid", 32'(vcnt - v0), 32'd0);
      chk("glitch_ferr", 32'(fcnt - f0), 32'd0);
      chk("glitch_busy_le9", 32'(busy_max <= 9), 32'd1);
      chk("glitch_busy_seen", 32'(busy_max >= 1), 32'd1);
      chk("glitch_idle", 32'(busy), 32'd0);
      frame(8'h3C, 1'b1);
      repeat (4) @(negedge clk);
      chk("3c_count", 32'(vcnt - v0), 32'd1);
      chk("3c_data", 32'(data), 32'h3C);

      // bad stop bit, then line held low
      v0 = vcnt; f0 = fcnt;
      frame(8'h55, 1'b0);
      repeat (40) @(negedge clk);
      chk("brk_ferr", 32'(fcnt - f0), 32'd1);
      chk("brk_valid", 32'(vcnt - v0), 32'd0);
      chk("brk_data", 32'(data), 32'h3C);
      chk("brk_busy", 32'(busy), 32'd1);
      rx = 1'b1;
      repeat (200) @(negedge clk);
      chk("brk_ferr_after", 32'(fcnt - f0), 32'd1);
      chk("brk_valid_after", 32'(vcnt - v0), 32'd0);
      chk("brk_idle", 32'(busy), 32'd0);
      chk("brk_no_both", 32'(both), 32'd0);

      // reset mid-DATA
      v0 = vcnt; f0 = fcnt;
      bitw(1'b0);
      bitw(1'b1);
      bitw(1'b0);
      bitw(1'b0);
      chk("abort_busy_pre", 32'(busy), 32'd1);
      rx  = 1'b1;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_data", 32'(data), 32'h0);
      chk("abort_valid", 32'(valid), 32'h0);
      chk("abort_ferr", 32'(frame_err), 32'h0);
      chk("abort_busy", 32'(busy), 32'h0);
      repeat (200) @(negedge clk);
      chk("abort_no_valid", 32'(vcnt - v0), 32'd0);
      chk("abort_no_ferr", 32'(fcnt - f0), 32'd0);
      frame(8'h81, 1'b1);
      repeat (4) @(negedge clk);
      chk("81_count", 32'(vcnt - v0), 32'd1);
      chk("81_data", 32'(data), 32'h81);

`ifdef UART_RX_PARITY_EN
      v0 = vcnt; f0 = fcnt;
      frame_par(8'h07, 1'b1);
      repeat (4) @(negedge clk);
      chk("par_ok_valid", 32'(vcnt - v0), 32'd1);
      chk("par_ok_data", 32'(data), 32'h07);
      chk("par_ok_ferr", 32'(fcnt - f0), 32'd0);
      frame_par(8'h07, 1'b0);
      repeat (4) @(negedge clk);
      chk("par_bad_valid", 32'(vcnt - v0), 32'd1);
      chk("par_bad_ferr", 32'(fcnt - f0), 32'd1);
      chk("par_bad_data", 32'(data), 32'h07);
`endif

      chk("never_both", 32'(both), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
